mul_share_ctrl: RTL

Sequencer and arbiter that shares one combinational 8x8 unsigned Wallace-tree multiplier between two requesters, e.g. the ALU issue path and a MAC/address helper.
- Registers the granted operands and holds them stable on the multiplier inputs for a programmable multicycle window.
- Captures the 16-bit product and returns it with a requester ID over a valid/ready response channel.
- Instantiated next to the multiplier in the ALU; the multiplier itself stays outside this block.

---
 rtl/mul_share_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one external combinational 8x8 multiplier between
// two requesters. It uses round-robin arbitration in IDLE. The operands stay
// registered for MC_CYCLES cycles. The product is then captured and returned
// with the owner ID over a valid/ready channel.
// Optional build macro: MUL_ZERO_BYPASS_EN. When it is defined, a zero operand
// skips the multicycle window and the block returns 0 directly.
module mul_share_ctrl #(
    parameter int unsigned MC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_prod,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MC_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        last_grant;
    logic        gnt0, gnt1;
    logic        accept;
    logic        acc_id;
    logic [7:0]  acc_a, acc_b;

    // Round-robin pick: on a tie, the requester not served last wins.
    always_comb begin
        gnt0   = req0_valid && (!req1_valid || last_grant);
        gnt1   = req1_valid && (!req0_valid || !last_grant);
        accept = (state == IDLE) && (gnt0 || gnt1);
        acc_id = gnt1;
        acc_a  = gnt1 ? req1_a : req0_a;
        acc_b  = gnt1 ? req1_b : req0_b;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MUL_ZERO_BYPASS_EN
                    if (acc_a == '0 || acc_b == '0) state_nx = DONE;
                    else                            state_nx = BUSY;
`else
                    state_nx = BUSY;
`endif
                end
            end
            BUSY:    if (cnt == '0) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: the ready signals are asserted only in IDLE.
    always_comb begin
        req0_ready = (state == IDLE) && gnt0;
        req1_ready = (state == IDLE) && gnt1;
        busy       = (state != IDLE);
        rsp_valid  = (state == DONE);
    end

    // Datapath: operand capture, window countdown, product capture.
    // mul_a/mul_b are loaded only on accept. They hold their value through
    // IDLE so the multiplier inputs do not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_id     <= 1'b0;
            rsp_prod   <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                mul_a      <= acc_a;
                mul_b      <= acc_b;
                rsp_id     <= acc_id;
                last_grant <= acc_id;
                cnt        <= CNT_INIT;
`ifdef MUL_ZERO_BYPASS_EN
                if (acc_a == '0 || acc_b == '0) rsp_prod <= '0;
`endif
            end else if (state == BUSY) begin
                if (cnt == '0) rsp_prod <= mul_p;
                else           cnt      <= cnt - 3'd1;
            end
        end
    end

endmodule
